alu_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the RV32I datapath built around the shared ALU. It fetches an instruction through a req/rdy instruction-memory handshake and decodes the opcode into the one-hot class flags and func3/func7/shamt fields the ALU consumes. It sequences EXEC/MEM/WB and drives the PC, IR, register-file and data-memory strobes, resolving branches from the ALU compare outputs EQ/EQM/EQM_U. A watchdog counter traps on a stalled memory.

---
 rtl/alu_ctrl_fsm.sv | 252 +++++++++++++++++++++++++
 tb/tb_alu_ctrl_fsm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: fetch handshake, opcode decode into ALU class flags,
// EXEC/MEM/WB sequencing with branch resolution, and a memory-stall watchdog that traps.
//
// state  | meaning
// FETCH  | request instruction, load IR on imem_rdy
// DECODE | classify opcode, register flags and func fields on exit
// EXEC   | ALU cycle; branches resolve and update PC here
// MEM    | data memory access, held until dmem_rdy
// WB     | register-file write and PC update
// TRAP   | sticky fault, all strobes off until rst
module alu_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        imem_rdy,
  input  logic        dmem_rdy,
  input  logic        EQ,
  input  logic        EQM,
  input  logic        EQM_U,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        isALUreg,
  output logic        isALUimm,
  output logic        isBranch,
  output logic        isJALR,
  output logic        isJAL,
  output logic        isAUIPC,
  output logic        isLUI,
  output logic        isLoad,
  output logic        isStore,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  shamt,
  output logic        trap,
  output logic        bus_err,
  output logic [2:0]  state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  // class vector bit positions
  localparam int C_ALUREG = 0;
  localparam int C_ALUIMM = 1;
  localparam int C_BRANCH = 2;
  localparam int C_JALR   = 3;
  localparam int C_JAL    = 4;
  localparam int C_AUIPC  = 5;
  localparam int C_LUI    = 6;
  localparam int C_LOAD   = 7;
  localparam int C_STORE  = 8;

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] cls_q, cls_d;
  logic [2:0] func3_q, func3_d;
  logic [6:0] func7_q, func7_d;
  logic [4:0] shamt_q, shamt_d;
  logic       trap_q, trap_d;
  logic       bus_err_q, bus_err_d;

  logic [8:0] dec_cls;
  logic [7:0] cnt_inc;
  logic       timeout;
  logic       br_legal;
  logic       br_taken;
  logic       unused_instr;

  assign unused_instr = ^{instr[19:15], instr[11:7]};
  assign cnt_inc      = cnt_q + 8'd1;
  assign timeout      = (cnt_inc == TIMEOUT_CNT);
  assign br_legal     = (func3_q[2:1] != 2'b01);

  always_comb begin
    dec_cls = '0;
    case (instr[6:0])
      7'b0110011: dec_cls[C_ALUREG] = 1'b1;
      7'b0010011: dec_cls[C_ALUIMM] = 1'b1;
      7'b1100011: dec_cls[C_BRANCH] = 1'b1;
      7'b1100111: dec_cls[C_JALR]   = 1'b1;
      7'b1101111: dec_cls[C_JAL]    = 1'b1;
      7'b0010111: dec_cls[C_AUIPC]  = 1'b1;
      7'b0110111: dec_cls[C_LUI]    = 1'b1;
      7'b0000011: dec_cls[C_LOAD]   = 1'b1;
      7'b0100011: dec_cls[C_STORE]  = 1'b1;
      default:    dec_cls           = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (func3_q)
      3'b000:  br_taken = EQ;
      3'b001:  br_taken = !EQ;
      3'b100:  br_taken = EQM;
      3'b101:  br_taken = !EQM;
      3'b110:  br_taken = EQM_U;
      3'b111:  br_taken = !EQM_U;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      cls_q     <= '0;
      func3_q   <= '0;
      func7_q   <= '0;
      shamt_q   <= '0;
      trap_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cls_q     <= cls_d;
      func3_q   <= func3_d;
      func7_q   <= func7_d;
      shamt_q   <= shamt_d;
      trap_q    <= trap_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    cls_d     = cls_q;
    func3_d   = func3_q;
    func7_d   = func7_q;
    shamt_d   = shamt_q;
    trap_d    = trap_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_FETCH: begin
        if (imem_rdy) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DECODE: begin
        cls_d   = dec_cls;
        func3_d = instr[14:12];
        shamt_d = instr[24:20];
        // only shifts-right-immediate and R-type carry func7; ADDI must never look like SUB
        if (dec_cls[C_ALUREG] || (dec_cls[C_ALUIMM] && instr[14:12] == 3'b101))
          func7_d = instr[31:25];
        else
          func7_d = '0;
        state_d = (|dec_cls) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (cls_q[C_LOAD] || cls_q[C_STORE])
          state_d = S_MEM;
        else if (cls_q[C_BRANCH])
          state_d = br_legal ? S_FETCH : S_TRAP;
        else
          state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_rdy) begin
          state_d = cls_q[C_LOAD] ? S_WB : S_FETCH;
        end else if (timeout) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    if (state_d == S_TRAP && state_q != S_TRAP) begin
      trap_d  = 1'b1;
      cls_d   = '0;
      func3_d = '0;
      func7_d = '0;
      shamt_d = '0;
    end
  end

  // rst gates the strobes so they fall together with the reset edge
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_re  = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'b00;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_rdy;
        end
        S_EXEC: begin
          if (cls_q[C_BRANCH] && br_legal) begin
            pc_we  = 1'b1;
            pc_sel = br_taken ? 2'b01 : 2'b00;
          end
        end
        S_MEM: begin
          dmem_re = cls_q[C_LOAD];
          dmem_we = cls_q[C_STORE];
          pc_we   = dmem_rdy && cls_q[C_STORE];
        end
        S_WB: begin
          rf_we  = 1'b1;
          pc_we  = 1'b1;
          pc_sel = cls_q[C_JAL] ? 2'b01 : (cls_q[C_JALR] ? 2'b10 : 2'b00);
        end
        default: ;
      endcase
    end
  end

  assign isALUreg = cls_q[C_ALUREG];
  assign isALUimm = cls_q[C_ALUIMM];
  assign isBranch = cls_q[C_BRANCH];
  assign isJALR   = cls_q[C_JALR];
  assign isJAL    = cls_q[C_JAL];
  assign isAUIPC  = cls_q[C_AUIPC];
  assign isLUI    = cls_q[C_LUI];
  assign isLoad   = cls_q[C_LOAD];
  assign isStore  = cls_q[C_STORE];
  assign func3    = func3_q;
  assign func7    = func7_q;
  assign shamt    = shamt_q;
  assign trap     = trap_q;
  assign bus_err  = bus_err_q;
  assign state    = state_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed bench for alu_ctrl_fsm: instruction-class walkthroughs, branch resolution,
// memory waits, fetch timeout boundary, illegal opcode and reset override.
module tb_alu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        imem_rdy, dmem_rdy, EQ, EQM, EQM_U;
  logic        imem_req, ir_we, dmem_re, dmem_we, rf_we, pc_we;
  logic [1:0]  pc_sel;
  logic        isALUreg, isALUimm, isBranch, isJALR, isJAL, isAUIPC, isLUI, isLoad, isStore;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  shamt;
  logic        trap, bus_err;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  alu_ctrl_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
    .EQ(EQ), .EQM(EQM), .EQM_U(EQM_U), .imem_req(imem_req), .ir_we(ir_we),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .isALUreg(isALUreg), .isALUimm(isALUimm), .isBranch(isBranch), .isJALR(isJALR),
    .isJAL(isJAL), .isAUIPC(isAUIPC), .isLUI(isLUI), .isLoad(isLoad), .isStore(isStore),
    .func3(func3), .func7(func7), .shamt(shamt), .trap(trap), .bus_err(bus_err),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // fetch with zero wait, leaves the FSM in EXEC
  task automatic fetch_to_exec(input logic [31:0] ins);
    instr    = ins;
    imem_rdy = 1'b1;
    #1;
    check("fetch_ir_we", {31'b0, ir_we}, 32'd1);
    cyc();
    imem_rdy = 1'b0;
    check("decode_state", {29'b0, state}, 32'd1);
    cyc();
    check("exec_state", {29'b0, state}, 32'd2);
  endtask

  initial begin
    rst = 1'b1; instr = '0; imem_rdy = 1'b0; dmem_rdy = 1'b0;
    EQ = 1'b0; EQM = 1'b0; EQM_U = 1'b0;
    cyc(); cyc();
    check("rst_state", {29'b0, state}, 32'd0);
    check("rst_strobes", {26'b0, imem_req, ir_we, dmem_re, dmem_we, rf_we, pc_we}, 32'd0);
    check("rst_trap", {30'b0, trap, bus_err}, 32'd0);
    rst = 1'b0;
    #1;
    check("fetch_req", {31'b0, imem_req}, 32'd1);

    // ADD x3,x1,x2
    fetch_to_exec(32'h002081B3);
    check("add_flag", {31'b0, isALUreg}, 32'd1);
    check("add_f3f7", {22'b0, func3, func7}, 32'd0);
    check("add_exec_wr", {30'b0, rf_we, pc_we}, 32'd0);
    cyc();
    check("add_wb_state", {29'b0, state}, 32'd4);
    check("add_wb", {28'b0, rf_we, pc_we, pc_sel}, 32'b1100);
    cyc();
    check("add_back_fetch", {29'b0, state}, 32'd0);
    check("add_fetch_wr", {30'b0, rf_we, pc_we}, 32'd0);

    // ADDI with upper bits 0100000: func7 must read 0
    fetch_to_exec({7'b0100000, 5'd5, 5'd1, 3'b000, 5'd3, 7'b0010011});
    check("addi_flag", {31'b0, isALUimm}, 32'd1);
    check("addi_func7", {25'b0, func7}, 32'd0);
    cyc(); cyc();
    // SRAI keeps func7 and shamt
    fetch_to_exec({7'b0100000, 5'd7, 5'd1, 3'b101, 5'd3, 7'b0010011});
    check("srai_func7", {25'b0, func7}, 32'h20);
    check("srai_shamt", {27'b0, shamt}, 32'd7);
    check("srai_func3", {29'b0, func3}, 32'd5);
    cyc(); cyc();

    // BLT taken on EQM
    EQM = 1'b1;
    fetch_to_exec({7'b0, 5'd2, 5'd1, 3'b100, 5'd0, 7'b1100011});
    check("blt_exec", {29'b0, isBranch, pc_we, pc_sel[0]} | {30'b0, pc_sel[1], 1'b0}, 32'b111);
    cyc();
    check("blt_done", {29'b0, state}, 32'd0);
    EQM = 1'b0;
    // BGEU not taken when EQM_U
    EQM_U = 1'b1;
    fetch_to_exec({7'b0, 5'd2, 5'd1, 3'b111, 5'd0, 7'b1100011});
    check("bgeu_exec", {29'b0, pc_we, pc_sel}, 32'b100);
    cyc();
    check("bgeu_done", {29'b0, state}, 32'd0);
    EQM_U = 1'b0;

    // LW with dmem_rdy after 3 wait cycles
    fetch_to_exec({12'd4, 5'd1, 3'b010, 5'd3, 7'b0000011});
    check("lw_exec_re", {31'b0, dmem_re}, 32'd0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      check("lw_mem_wait", {28'b0, state, dmem_re}, {28'b0, 3'd3, 1'b1});
      cyc();
    end
    dmem_rdy = 1'b1;
    #1;
    check("lw_mem_rdy", {28'b0, state, dmem_re}, {28'b0, 3'd3, 1'b1});
    cyc();
    dmem_rdy = 1'b0;
    check("lw_wb", {28'b0, state, rf_we}, {28'b0, 3'd4, 1'b1});
    check("lw_wb_re", {31'b0, dmem_re}, 32'd0);
    cyc();
    check("lw_done", {29'b0, state}, 32'd0);

    // JAL and JALR pick their PC sources in WB
    fetch_to_exec({20'h00010, 5'd1, 7'b1101111});
    cyc();
    check("jal_wb_sel", {30'b0, pc_sel}, 32'b01);
    cyc();
    fetch_to_exec({12'd8, 5'd1, 3'b000, 5'd1, 7'b1100111});
    check("jalr_flag", {31'b0, isJALR}, 32'd1);
    cyc();
    check("jalr_wb_sel", {30'b0, pc_sel}, 32'b10);
    cyc();

    // rdy on the last allowed wait cycle is accepted
    instr = {20'hABCDE, 5'd4, 7'b0110111};
    for (int i = 0; i < 14; i++) cyc();
    imem_rdy = 1'b1;
    #1;
    check("edge_ir_we", {31'b0, ir_we}, 32'd1);
    cyc();
    imem_rdy = 1'b0;
    check("edge_decode", {29'b0, state}, 32'd1);
    cyc();
    check("lui_flag", {31'b0, isLUI}, 32'd1);
    cyc(); cyc();
    check("lui_done", {29'b0, state}, 32'd0);

    // fetch stall: 15 FETCH cycles then TRAP
    for (int i = 0; i < 14; i++) cyc();
    check("stall_still_fetch", {29'b0, state}, 32'd0);
    cyc();
    check("stall_trap_state", {29'b0, state}, 32'd7);
    check("stall_trap_bits", {30'b0, trap, bus_err}, 32'b11);
    check("stall_flags_clr", {23'b0, isALUreg, isALUimm, isBranch, isJALR, isJAL, isAUIPC, isLUI, isLoad, isStore}, 32'd0);
    imem_rdy = 1'b1;
    #1;
    check("trap_no_req", {30'b0, imem_req, ir_we}, 32'd0);
    cyc();
    check("trap_held", {29'b0, state}, 32'd7);
    imem_rdy = 1'b0;
    rst = 1'b1;
    cyc();
    check("trap_rst_state", {29'b0, state}, 32'd0);
    check("trap_rst_outs", {24'b0, imem_req, ir_we, dmem_re, dmem_we, rf_we, pc_we, trap, bus_err}, 32'd0);
    rst = 1'b0;

    // illegal opcode 1110011
    instr = 32'h00000073;
    imem_rdy = 1'b1;
    cyc();
    imem_rdy = 1'b0;
    cyc();
    check("ill_state", {29'b0, state}, 32'd7);
    check("ill_bits", {30'b0, trap, bus_err}, 32'b10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // SW interrupted by reset in MEM
    fetch_to_exec({7'd0, 5'd2, 5'd1, 3'b010, 5'd8, 7'b0100011});
    cyc();
    check("sw_mem_we", {28'b0, state, dmem_we}, {28'b0, 3'd3, 1'b1});
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("sw_rst", {28'b0, state, dmem_we}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
